// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue sequencer in front of ALU_16bit.
// One command in flight; results handed off with valid/ready.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [1:0]  cmd_sel,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic [1:0]  alu_selected_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_sel,
  output logic        res_err,
  output logic        busy,
  output logic [4:0]  fifo_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  logic [33:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [4:0]    count_nxt;
  logic [2:0]    cnt;
  logic [1:0]    iss_sel;
  logic          push;
  logic          pop;

  assign push = cmd_valid & cmd_ready;
  assign pop  = (state == IDLE) && (count != 5'd0);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 5'd1;
    else if (!push && pop)
      count_nxt = count - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_sel, cmd_b, cmd_a};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
      cnt       <= '0;
      iss_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sel   <= '0;
      res_err   <= 1'b0;
    end else begin
      count     <= count_nxt;
      // Registered so ready rises one edge after reset drops
      cmd_ready <= (count_nxt != 5'(FIFO_DEPTH));
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case (state)
        IDLE: begin
          if (pop) begin
            {alu_sel, alu_b, alu_a} <= mem[rd_ptr];
            iss_sel <= mem[rd_ptr][33:32];
            cnt     <= 3'(ALU_LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            res_data  <= alu_out;
            res_sel   <= iss_sel;
            res_err   <= (alu_selected_op != iss_sel);
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (count != 5'd0) || (state != IDLE);
  assign fifo_count = count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered ALU stub.
// Results are collected at handshake edges and checked in order.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [1:0]  cmd_sel;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_sel;
  logic [31:0] alu_out;
  logic [1:0]  alu_selected_op;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_sel;
  logic        res_err;
  logic        busy;
  logic [4:0]  fifo_count;

  logic        force_op;
  int          vectors = 0;
  int          errors = 0;
  logic [34:0] rq[$];

  logic [15:0] t2a [4] = '{16'd32, 16'd8, 16'd12, 16'd12};
  logic [15:0] t2b [4] = '{16'd16, 16'd8, 16'd2, 16'd2};
  logic [1:0]  t2s [4] = '{2'b01, 2'b10, 2'b00, 2'b01};
  logic [31:0] t2r [4] = '{32'd16, 32'd64, 32'd14, 32'd10};

  logic [15:0] t3a [6] = '{16'd1, 16'd9, 16'd7, 16'd100,
                           16'hFFFF, 16'd3};
  logic [15:0] t3b [6] = '{16'd1, 16'd5, 16'd6, 16'd3,
                           16'hFFFF, 16'd4};
  logic [1:0]  t3s [6] = '{2'b00, 2'b01, 2'b10, 2'b11,
                           2'b10, 2'b00};
  logic [31:0] t3r [6] = '{32'd2, 32'd4, 32'd42, 32'd12,
                           32'hFFFE0001, 32'd7};

  alu_cmd_sequencer #(
    .FIFO_DEPTH (4),
    .ALU_LATENCY(1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_sel        (cmd_sel),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_sel        (alu_sel),
    .alu_out        (alu_out),
    .alu_selected_op(alu_selected_op),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_sel        (res_sel),
    .res_err        (res_err),
    .busy           (busy),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  // One-cycle ALU stub
  always @(posedge clk) begin
    case (alu_sel)
      2'b00:   alu_out <= 32'(alu_a) + 32'(alu_b);
      2'b01:   alu_out <= 32'(alu_a) - 32'(alu_b);
      2'b10:   alu_out <= 32'(alu_a) * 32'(alu_b);
      default: alu_out <= 32'(alu_a >> alu_b);
    endcase
    alu_selected_op <= force_op ? 2'b11 : alu_sel;
  end

  always @(posedge clk) begin
    if (!reset && res_valid && res_ready)
      rq.push_back({res_data, res_sel, res_err});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input string tag,
                            input logic [31:0] d,
                            input logic [1:0] s,
                            input logic e);
    int n;
    logic [34:0] r;
    n = 0;
    while (rq.size() == 0 && n < 40) begin
      step();
      n++;
    end
    check({tag, " present"}, 32'(rq.size() != 0), 32'd1);
    if (rq.size() != 0) begin
      r = rq.pop_front();
      check({tag, " data"}, r[34:3], d);
      check({tag, " sel"}, 32'(r[2:1]), 32'(s));
      check({tag, " err"}, 32'(r[0]), 32'(e));
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int peak;
    logic dropped;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_sel   = '0;
    res_ready = 1'b1;
    force_op  = 1'b0;
    step();
    step();
    check("rst cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst alu_a", 32'(alu_a), 32'd0);
    check("rst res_data", res_data, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    step();
    check("post rst ready", 32'(cmd_ready), 32'd1);

    // Single command
    cmd_valid = 1'b1;
    cmd_a = 16'd12;
    cmd_b = 16'd2;
    cmd_sel = 2'b00;
    step();
    cmd_valid = 1'b0;
    check("t1 count", 32'(fifo_count), 32'd1);
    step();
    check("t1 alu_a", 32'(alu_a), 32'd12);
    check("t1 alu_b", 32'(alu_b), 32'd2);
    check("t1 busy", 32'(busy), 32'd1);
    step();
    check("t1 early valid", 32'(res_valid), 32'd0);
    step();
    check("t1 valid", 32'(res_valid), 32'd1);
    check("t1 data", res_data, 32'd14);
    expect_res("t1", 32'd14, 2'b00, 1'b0);
    step();
    check("t1 idle busy", 32'(busy), 32'd0);

    // Back-to-back queue
    peak = 0;
    dropped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!cmd_ready) dropped = 1'b1;
      cmd_valid = 1'b1;
      cmd_a = t2a[i];
      cmd_b = t2b[i];
      cmd_sel = t2s[i];
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      expect_res("t2", t2r[i], t2s[i], 1'b0);
    check("t2 peak", 32'(peak), 32'd3);
    check("t2 ready drop", 32'(dropped), 32'd0);

    // Full FIFO plus backpressure
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_ready("t3 push");
      cmd_valid = 1'b1;
      cmd_a = t3a[i];
      cmd_b = t3b[i];
      cmd_sel = t3s[i];
      step();
      cmd_valid = 1'b0;
    end
    check("t3 full ready", 32'(cmd_ready), 32'd0);
    check("t3 full count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4 valid", 32'(res_valid), 32'd1);
      check("t4 data", res_data, 32'd2);
      check("t4 alu_a", 32'(alu_a), 32'd1);
      check("t4 alu_b", 32'(alu_b), 32'd1);
      check("t4 alu_sel", 32'(alu_sel), 32'd0);
      check("t4 count", 32'(fifo_count), 32'd4);
    end
    res_ready = 1'b1;
    wait_ready("t3 last");
    cmd_valid = 1'b1;
    cmd_a = t3a[5];
    cmd_b = t3b[5];
    cmd_sel = t3s[5];
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++)
      expect_res("t3", t3r[i], t3s[i], 1'b0);

    // Echo mismatch
    force_op = 1'b1;
    cmd_valid = 1'b1;
    cmd_a = 16'd3;
    cmd_b = 16'd5;
    cmd_sel = 2'b10;
    step();
    cmd_valid = 1'b0;
    expect_res("t5", 32'd15, 2'b10, 1'b1);
    force_op = 1'b0;
    step();

    // Reset during WAIT with two queued
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_a = t2a[i];
      cmd_b = t2b[i];
      cmd_sel = t2s[i];
      step();
    end
    cmd_valid = 1'b0;
    check("t6 queued", 32'(fifo_count), 32'd2);
    check("t6 in wait", 32'(res_valid), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6 count", 32'(fifo_count), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 alu_a", 32'(alu_a), 32'd0);
    check("t6 alu_sel", 32'(alu_sel), 32'd0);
    check("t6 res_valid", 32'(res_valid), 32'd0);
    check("t6 cmd_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 15; i++) step();
    check("t6 no results", 32'(rq.size()), 32'd0);
    check("t6 idle", 32'(busy), 32'd0);
    check("t6 ready back", 32'(cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
